display_rr_arbiter: RTL and testbench

- Round-robin scheduler that shares the board's 7-segment display (SEG) between NREQ requesters.
- Uses a rotating one-hot priority pointer, the same shift-and-wrap structure as the one-hot display ring counter.
- Each grant is held for HOLD_CYCLES clocks, or less on early release. The owner's data nibble is decoded to SEG, and owner/state is exported for the LEDs.

---
 rtl/display_rr_arbiter.sv | 87 ++++++++
 tb/tb_display_rr_arbiter.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/display_rr_arbiter.sv
// display_rr_arbiter: round-robin owner of the 7-segment display with a rotating one-hot priority pointer.
// Define ARB_LOCK_EN to add a lock input that freezes the owner's hold countdown.
module display_rr_arbiter #(
  parameter int NREQ        = 4,
  parameter int HOLD_CYCLES = 4,
  parameter int DATA_BITS   = 4
) (
  input  logic                      clk_2,
  input  logic                      reset,
`ifdef ARB_LOCK_EN
  input  logic                      lock,
`endif
  input  logic [NREQ-1:0]           req,
  input  logic [NREQ*DATA_BITS-1:0] req_data,
  output logic [NREQ-1:0]           grant,
  output logic [1:0]                owner,
  output logic                      busy,
  output logic [7:0]                SEG
);
  typedef enum logic {IDLE, GRANT} state_t;
  localparam logic [127:0] HEX = {8'h71, 8'h79, 8'h5E, 8'h39, 8'h7C, 8'h77, 8'h6F, 8'h7F,
                                  8'h07, 8'h7D, 8'h6D, 8'h66, 8'h4F, 8'h5B, 8'h06, 8'h3F};
  localparam logic [2*NREQ-1:0] ONE = 1;
  state_t               state_q, state_d;
  logic [NREQ-1:0]      grant_q, grant_d, ptr_q, ptr_d, nptr, win;
  logic [1:0]           owner_q, owner_d;
  logic [3:0]           hold_q, hold_d;
  logic                 lk, fin;
  logic [DATA_BITS-1:0] nib;
  // Doubled request vector: mask off bits below the pointer, keep the lowest survivor, fold back.
  function automatic logic [NREQ-1:0] pick(input logic [NREQ-1:0] r, input logic [NREQ-1:0] p);
    logic [2*NREQ-1:0] m;
    m = {r, r} & ~({{NREQ{1'b0}}, p} - ONE);
    m = m & -m;
    return m[NREQ-1:0] | m[2*NREQ-1:NREQ];
  endfunction
  function automatic logic [1:0] idx(input logic [NREQ-1:0] g);
    logic [1:0] r;
    r = 2'd0;
    for (int i = 0; i < NREQ; i++) if (g[i]) r = 2'(i);
    return r;
  endfunction
`ifdef ARB_LOCK_EN
  assign lk = lock & req[owner_q];
`else
  assign lk = 1'b0;
`endif
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    hold_d  = hold_q;
    fin     = !req[owner_q] || (hold_q == 4'd0 && !lk);
    nptr    = state_q == GRANT ? {grant_q[NREQ-2:0], grant_q[NREQ-1]} : ptr_q;
    win     = pick(req, nptr);
    if (state_q == IDLE || fin) begin
      ptr_d   = nptr;
      grant_d = win;
      owner_d = idx(win);
      state_d = |win ? GRANT : IDLE;
      hold_d  = 4'(HOLD_CYCLES - 1);
    end else begin
      hold_d  = lk ? hold_q : hold_q - 4'd1;
    end
  end
  always_ff @(posedge clk_2 or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      grant_q <= '0;
      owner_q <= 2'd0;
      ptr_q   <= NREQ'(1);
      hold_q  <= 4'd0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      hold_q  <= hold_d;
    end
  end
  assign grant = grant_q;
  assign owner = owner_q;
  assign busy  = state_q == GRANT;
  assign nib   = req_data[owner_q*DATA_BITS +: DATA_BITS];
  assign SEG   = busy ? HEX[nib*8 +: 8] : 8'h00;
endmodule

// File: tb/tb_display_rr_arbiter.sv
// tb_display_rr_arbiter: directed scenarios plus randomized traffic against an index-based scheduling model.
module tb_display_rr_arbiter;
  localparam int N = 4, H = 4;
`ifdef ARB_LOCK_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif
  logic clk_2 = 1'b0, reset = 1'b0, lock_v = 1'b0;
  logic [3:0] req = '0;
  logic [15:0] req_data = '0;
  logic [3:0] grant;
  logic [1:0] owner;
  logic busy;
  logic [7:0] SEG;
  int pass_cnt = 0, total = 0;
  int m_busy, m_own, m_used, m_pri;
  logic [7:0] hex [16] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                           8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71};

  always #5 clk_2 = ~clk_2;

  display_rr_arbiter dut (
    .clk_2(clk_2), .reset(reset),
`ifdef ARB_LOCK_EN
    .lock(lock_v),
`endif
    .req(req), .req_data(req_data), .grant(grant), .owner(owner), .busy(busy), .SEG(SEG));

  function automatic int first_from(input logic [3:0] r, input int s);
    for (int k = 0; k < N; k++) if (r[(s + k) % N]) return (s + k) % N;
    return -1;
  endfunction

  task automatic model_reset;
    m_busy = 0; m_own = 0; m_used = 0; m_pri = 0;
  endtask

  // Advance the model by one clock using the inputs present just before the edge.
  task automatic model_step;
    int j;
    bit lk;
    lk = LOCK_EN && lock_v && m_busy != 0 && req[m_own];
    if (m_busy == 0 || !req[m_own] || (m_used >= H && !lk)) begin
      if (m_busy != 0) m_pri = (m_own + 1) % N;
      j = first_from(req, m_pri);
      m_busy = j >= 0 ? 1 : 0;
      m_own  = j >= 0 ? j : 0;
      m_used = 1;
    end else if (!lk) m_used++;
  endtask

  function automatic logic [14:0] exp_vec();
    logic [3:0] g;
    logic [7:0] s;
    g = m_busy != 0 ? 4'(1 << m_own) : 4'd0;
    s = m_busy != 0 ? hex[req_data[m_own*4 +: 4]] : 8'h00;
    return {g, 2'(m_own), m_busy != 0, s};
  endfunction

  task automatic tick;
    model_step();
    @(posedge clk_2);
    #1;
  endtask

  task automatic do_reset;
    reset = 1'b0; req = '0; lock_v = 1'b0;
    #1;
    model_reset();
    @(negedge clk_2);
    reset = 1'b1;
  endtask

  task automatic test_reset;
    #2;
    total++;
    if ({grant, owner, busy, SEG} !== 15'd0) $display("FAIL reset_state: got %h expected 0", {grant, owner, busy, SEG});
    else pass_cnt++;
    model_reset();
    @(negedge clk_2);
    reset = 1'b1;
    req = 4'b1111;
    tick();
    total++;
    if (grant !== 4'b0001) $display("FAIL reset_first_grant: got %b expected 0001", grant);
    else pass_cnt++;
  endtask

  task automatic test_single;
    do_reset();
    req_data = 16'($urandom);
    req_data[7:4] = 4'h5;
    req = 4'b0010;
    for (int c = 0; c < 4; c++) begin
      tick();
      total++;
      if ({grant, owner, busy, SEG} !== {4'b0010, 2'd1, 1'b1, 8'h6D})
        $display("FAIL single c%0d: got %h expected %h", c, {grant, owner, busy, SEG}, {4'b0010, 2'd1, 1'b1, 8'h6D});
      else pass_cnt++;
    end
    req = '0;
    tick();
    total++;
    if ({grant, busy, SEG} !== 13'd0) $display("FAIL single_idle: got %h expected 0", {grant, busy, SEG});
    else pass_cnt++;
  endtask

  task automatic test_full_load;
    logic [3:0] g;
    do_reset();
    req_data = 16'h4321;
    req = 4'b1111;
    for (int c = 0; c < 17; c++) begin
      tick();
      g = 4'(1 << ((c / 4) % 4));
      total++;
      if (grant !== g || SEG !== hex[((c / 4) % 4) + 1])
        $display("FAIL full_load c%0d: got grant %b seg %h expected grant %b seg %h", c, grant, SEG, g, hex[((c / 4) % 4) + 1]);
      else pass_cnt++;
    end
  endtask

  task automatic test_early_release;
    do_reset();
    req = 4'b0101;
    for (int c = 0; c < 2; c++) begin
      tick();
      total++;
      if (grant !== 4'b0001) $display("FAIL early_first c%0d: got %b expected 0001", c, grant);
      else pass_cnt++;
    end
    req = 4'b0100;
    for (int c = 0; c < 4; c++) begin
      tick();
      total++;
      if (grant !== 4'b0100) $display("FAIL early_next c%0d: got %b expected 0100", c, grant);
      else pass_cnt++;
    end
  endtask

  task automatic test_wrap;
    do_reset();
    req = 4'b1000;
    for (int c = 0; c < 4; c++) begin
      tick();
      total++;
      if (grant !== 4'b1000) $display("FAIL wrap_hold c%0d: got %b expected 1000", c, grant);
      else pass_cnt++;
      req = 4'b1001;
    end
    for (int c = 0; c < 4; c++) begin
      tick();
      total++;
      if (grant !== 4'b0001) $display("FAIL wrap_next c%0d: got %b expected 0001", c, grant);
      else pass_cnt++;
    end
    tick();
    total++;
    if (grant !== 4'b1000) $display("FAIL wrap_back: got %b expected 1000", grant);
    else pass_cnt++;
  endtask

  task automatic test_lock;
    do_reset();
    req = 4'b0011;
`ifdef ARB_LOCK_EN
    lock_v = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      total++;
      if (grant !== 4'b0001) $display("FAIL lock_held c%0d: got %b expected 0001", c, grant);
      else pass_cnt++;
    end
    lock_v = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      total++;
      if (grant !== 4'b0001) $display("FAIL lock_drain c%0d: got %b expected 0001", c, grant);
      else pass_cnt++;
    end
`else
    for (int c = 0; c < 4; c++) begin
      tick();
      total++;
      if (grant !== 4'b0001) $display("FAIL nolock_hold c%0d: got %b expected 0001", c, grant);
      else pass_cnt++;
    end
`endif
    tick();
    total++;
    if (grant !== 4'b0010) $display("FAIL lock_handoff: got %b expected 0010", grant);
    else pass_cnt++;
  endtask

  task automatic test_async_reset;
    do_reset();
    req_data = 16'($urandom) | 16'h0F00;
    req = 4'b0100;
    tick();
    tick();
    #2;
    reset = 1'b0;
    #1;
    total++;
    if ({grant, owner, busy, SEG} !== 15'd0) $display("FAIL async_reset: got %h expected 0", {grant, owner, busy, SEG});
    else pass_cnt++;
    model_reset();
    @(negedge clk_2);
    reset = 1'b1;
    req = 4'b1111;
    tick();
    total++;
    if (grant !== 4'b0001) $display("FAIL async_restart: got %b expected 0001", grant);
    else pass_cnt++;
  endtask

  task automatic test_random;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      for (int b = 0; b < N; b++) if ($urandom_range(3) == 0) req[b] = ~req[b];
      req_data = 16'($urandom);
      lock_v = LOCK_EN && $urandom_range(3) == 0;
      tick();
      total++;
      if ({grant, owner, busy, SEG} !== exp_vec())
        $display("FAIL random c%0d: got %h expected %h", c, {grant, owner, busy, SEG}, exp_vec());
      else pass_cnt++;
      total++;
      if (!$onehot0(grant)) $display("FAIL random_onehot c%0d: got %b expected one-hot or zero", c, grant);
      else pass_cnt++;
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_full_load();
    test_early_release();
    test_wrap();
    test_lock();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
